// File: rtl/pe_weight_loader.sv
// Weight/bias loader: pulls a packed word stream and serialises it into per-core weight shift
// strobes and one bias write per PE core. Define WEIGHT_LOADER_CHECKSUM_EN for a running input checksum.
module pe_weight_loader #(
  parameter int WEIGHT_WIDTH  = 16,
  parameter int FEATURE_WIDTH = 16,
  parameter int BIAS_WIDTH    = WEIGHT_WIDTH + FEATURE_WIDTH,
  parameter int PE_CORE_NUM   = 8,
  parameter int KERNEL_SIZE   = 9
) (
  input  logic                    DSP_clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    load_done,
  input  logic [WEIGHT_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WEIGHT_WIDTH-1:0] weight,
  output logic [PE_CORE_NUM-1:0]  weight_valid,
  output logic [BIAS_WIDTH-1:0]   bias,
  output logic [PE_CORE_NUM-1:0]  bias_valid,
  output logic [31:0]             checksum
);

  localparam int BW     = BIAS_WIDTH / WEIGHT_WIDTH;
  localparam int CORE_W = (PE_CORE_NUM > 1) ? $clog2(PE_CORE_NUM) : 1;
  localparam int WCNT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int BCNT_W = (BW > 1) ? $clog2(BW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CORE_W-1:0]       core_cnt;
  logic [WCNT_W-1:0]       w_cnt;
  logic [BCNT_W-1:0]       b_cnt;
  logic [BIAS_WIDTH-1:0]   bias_asm;
  logic [BIAS_WIDTH-1:0]   bias_next;
  logic [PE_CORE_NUM-1:0]  core_onehot;
  logic                    hs;
  logic                    start_ok;
  logic                    last_w;
  logic                    last_b;
  logic                    last_core;

  // Handshake: a word transfers on a rising edge where in_valid & in_ready are both high;
  // in_ready is a decode of the state register only and never looks at in_valid.
  assign in_ready    = (state == LOAD_W) || (state == LOAD_B);
  assign hs          = in_valid & in_ready;
  assign start_ok    = (state == IDLE) & start & ~load_done;
  assign last_w      = (w_cnt == WCNT_W'(KERNEL_SIZE - 1));
  assign last_b      = (b_cnt == BCNT_W'(BW - 1));
  assign last_core   = (core_cnt == CORE_W'(PE_CORE_NUM - 1));
  assign core_onehot = PE_CORE_NUM'(1) << core_cnt;

  always_ff @(posedge DSP_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD_W;
      LOAD_W:  if (hs && last_w) state_next = LOAD_B;
      LOAD_B:  if (hs && last_b) state_next = last_core ? DONE : LOAD_W;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bias assembly with the current word dropped into its slice, so the final word is included.
  always_comb begin
    bias_next = bias_asm;
    bias_next[b_cnt*WEIGHT_WIDTH +: WEIGHT_WIDTH] = in_data;
  end

  always_ff @(posedge DSP_clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      load_done    <= 1'b0;
      weight       <= '0;
      weight_valid <= '0;
      bias         <= '0;
      bias_valid   <= '0;
      bias_asm     <= '0;
      core_cnt     <= '0;
      w_cnt        <= '0;
      b_cnt        <= '0;
    end else begin
      weight_valid <= '0;
      bias_valid   <= '0;
      load_done    <= (state == DONE);
      if (state == DONE) busy <= 1'b0;
      if (start_ok) begin
        busy     <= 1'b1;
        core_cnt <= '0;
        w_cnt    <= '0;
        b_cnt    <= '0;
      end
      if (hs && state == LOAD_W) begin
        weight       <= in_data;
        weight_valid <= core_onehot;
        if (last_w) begin
          w_cnt <= '0;
          b_cnt <= '0;
        end else begin
          w_cnt <= w_cnt + 1'b1;
        end
      end
      if (hs && state == LOAD_B) begin
        bias_asm <= bias_next;
        if (last_b) begin
          b_cnt      <= '0;
          w_cnt      <= '0;
          bias       <= bias_next;
          bias_valid <= core_onehot;
          core_cnt   <= last_core ? '0 : core_cnt + 1'b1;
        end else begin
          b_cnt <= b_cnt + 1'b1;
        end
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [31:0] cks;

  always_ff @(posedge DSP_clk or posedge rst) begin
    if (rst)           cks <= '0;
    else if (start_ok) cks <= '0;
    else if (hs)       cks <= cks + 32'(in_data);
  end

  assign checksum = cks;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: randomized stream/valid stimulus against a handshake-count model
// that derives core, slot and bias slice from the running word index.
module tb_pe_weight_loader;
  localparam int W     = 16;
  localparam int BWID  = 32;
  localparam int N     = 8;
  localparam int K     = 9;
  localparam int BW    = BWID / W;
  localparam int PER   = K + BW;
  localparam int TOTAL = PER * N;

  logic            clk = 0;
  logic            rst, start, in_valid;
  logic [W-1:0]    in_data;
  logic            busy, load_done, in_ready;
  logic [W-1:0]    weight;
  logic [N-1:0]    weight_valid, bias_valid;
  logic [BWID-1:0] bias;
  logic [31:0]     checksum;

  int tests = 0;
  int fails = 0;

  pe_weight_loader dut (
    .DSP_clk(clk), .rst(rst), .start(start), .busy(busy), .load_done(load_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .weight(weight),
    .weight_valid(weight_valid), .bias(bias), .bias_valid(bias_valid), .checksum(checksum)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]    exp_q[$];
  logic            m_busy, m_ready, exp_done;
  logic [N-1:0]    exp_wv, exp_bv;
  logic [W-1:0]    exp_w;
  logic [BWID-1:0] exp_b, m_acc;
  logic [31:0]     exp_cks;
  int              m_n, m_done_cnt;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_ready = 0; exp_done = 0; exp_wv = '0; exp_bv = '0;
        exp_w = '0; exp_b = '0; m_acc = '0; exp_cks = '0; m_n = 0; m_done_cnt = 0;
        exp_q.delete();
      end else begin
        bit hs, st_ok;
        int core, pos;
        hs    = in_valid && m_ready;
        st_ok = start && !m_busy && !exp_done;
        exp_wv = '0; exp_bv = '0; exp_done = 0;
        if (m_done_cnt > 0) begin
          m_done_cnt--;
          if (m_done_cnt == 0) begin exp_done = 1; m_busy = 0; end
        end
        if (hs) begin
          core = m_n / PER;
          pos  = m_n % PER;
          if (pos < K) begin
            exp_wv = N'(1) << core;
            exp_w  = in_data;
            exp_q.push_back(in_data);
          end else begin
            m_acc[(pos-K)*W +: W] = in_data;
            if (pos == PER - 1) begin
              exp_bv = N'(1) << core;
              exp_b  = m_acc;
            end
          end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          exp_cks = exp_cks + 32'(in_data);
`endif
          m_n++;
          if (m_n == TOTAL) begin m_ready = 0; m_done_cnt = 1; end
        end
        if (st_ok) begin
          m_busy = 1; m_ready = 1; m_n = 0; exp_cks = '0;
        end
      end
    end
  end

  // ---------------- compare process + captures ----------------
  logic [W-1:0]    w3_q[$];
  logic [BWID-1:0] cap_b0, cap_b7;
  logic [31:0]     cap_cks;
  logic [N-1:0]    first_wv;
  logic [W-1:0]    first_w;
  bit              got_first;
  int              done_seen, w0_cnt, cyc, bv7_cyc, done_cyc;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", load_done, 0);
      check("rst_ready", in_ready, 0);
      check("rst_wv", weight_valid, 0);
      check("rst_bv", bias_valid, 0);
      check("rst_weight", weight, 0);
      check("rst_bias", bias, 0);
      check("rst_cks", checksum, 0);
    end else begin
      check("busy", busy, m_busy);
      check("in_ready", in_ready, m_ready);
      check("weight_valid", weight_valid, exp_wv);
      check("weight", weight, exp_w);
      check("bias_valid", bias_valid, exp_bv);
      check("bias", bias, exp_b);
      check("load_done", load_done, exp_done);
      check("checksum", checksum, exp_cks);
      if (weight_valid != '0) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_weight: strobe %0h with empty expected queue", weight_valid);
        end else begin
          check("sb_weight", weight, exp_q.pop_front());
        end
        if (!got_first) begin got_first = 1; first_wv = weight_valid; first_w = weight; end
      end
      if (weight_valid[3]) w3_q.push_back(weight);
      if (weight_valid[0]) w0_cnt++;
      if (bias_valid[0]) cap_b0 = bias;
      if (bias_valid[7]) begin cap_b7 = bias; bv7_cyc = cyc; end
      if (load_done) begin done_seen++; cap_cks = checksum; done_cyc = cyc; end
    end
  end

  // ---------------- driver ----------------
  // policy: 0 = valid always, 1 = random valid, 2 = toggle valid during core 3 weights
  // dmode: 0 = words 1..88, 1 = all 0xFFFF, 2 = random
  task automatic run_load(input int policy, input int dmode, input int restart_at,
                          input int rst_at, input int stall);
    logic [W-1:0] words[TOTAL];
    int   w, n_cyc;
    bit   done, hs_p, tog, sent;
    for (int i = 0; i < TOTAL; i++)
      words[i] = (dmode == 0) ? W'(i + 1) : (dmode == 1) ? 16'hFFFF : W'($urandom);
    w3_q.delete(); done_seen = 0; w0_cnt = 0; got_first = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (stall) begin
      in_valid = 0; in_data = W'($urandom);
      @(negedge clk);
      check("stall_busy", busy, 1);
      check("stall_ready", in_ready, 1);
      check("stall_wv", weight_valid, 0);
      check("stall_done", load_done, 0);
      @(posedge clk); #1;
    end
    w = 0; n_cyc = 0; done = 0; tog = 1; sent = 0;
    while (!done && n_cyc < 3000) begin
      if (rst_at >= 0 && w == rst_at) begin
        in_valid = 0; rst = 1;
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        return;
      end
      case (policy)
        0:       in_valid = 1;
        1:       in_valid = ($urandom_range(0, 9) < 7);
        default: begin
          if (w >= 3 * PER && w < 3 * PER + K) begin in_valid = tog; tog = ~tog; end
          else in_valid = 1;
        end
      endcase
      if (w >= TOTAL) in_valid = 0;
      in_data = in_valid ? words[w] : W'($urandom);
      start = (w == restart_at && !sent);
      if (start) sent = 1;
      @(negedge clk);
      hs_p = in_valid && in_ready;
      if (load_done) done = 1;
      @(posedge clk); #1;
      start = 0;
      if (hs_p) w++;
      n_cyc++;
    end
    in_valid = 0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL load_timeout: no load_done after %0d cycles, %0d words", n_cyc, w);
    end
    repeat (3) @(posedge clk);
    #1;
    check("hs_total", w, TOTAL);
    check("done_count", done_seen, 1);
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // words 1..88, valid held high
    run_load(0, 0, -1, -1, 0);
    check("t1_first_wv", first_wv, 8'h01);
    check("t1_first_w", first_w, 1);
    check("t1_w0_pulses", w0_cnt, 9);
    check("t1_bias0", cap_b0, 32'h000B000A);
    check("t1_bias7", cap_b7, 32'h00580057);
    check("t1_done_after_bv7", done_cyc, bv7_cyc + 1);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    check("t1_cks", cap_cks, 3916);
`else
    check("t1_cks_off", cap_cks, 0);
`endif

    // valid toggling during core 3 weights
    run_load(2, 0, -1, -1, 0);
    check("t2_w3_count", w3_q.size(), 9);
    for (int i = 0; i < 9 && i < w3_q.size(); i++) check("t2_w3_seq", w3_q[i], 34 + i);

    // start re-pulsed mid-load at handshake 40
    run_load(1, 2, 40, -1, 0);

    // reset at handshake 50, then a fresh load
    run_load(1, 0, -1, 50, 0);
    run_load(0, 0, -1, -1, 0);
    check("t4_first_wv", first_wv, 8'h01);
    check("t4_first_w", first_w, 1);
    check("t4_bias0", cap_b0, 32'h000B000A);

    // 20-cycle stall after start
    run_load(1, 2, -1, -1, 20);

    // all-ones load
    run_load(1, 1, -1, -1, 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    check("t6_cks", cap_cks, 5767080);
`else
    check("t6_cks_off", cap_cks, 0);
`endif
    check("t6_bias7", cap_b7, 32'hFFFFFFFF);

    repeat (3) run_load(1, 2, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
